// File: rtl/rv32i_mem_stage.sv
// RV32I pipeline memory-access stage: turns an execute-stage request into a
// word-aligned data-RAM access, formats load data for writeback and flags
// misaligned / out-of-range accesses.
// Optional build macro MEM_STAGE_PERF_EN adds saturating perf counters.
module rv32i_mem_stage #(
  parameter int unsigned DMEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        ex_we,
  input  logic        ex_re,
  input  logic [1:0]  ex_width,
  input  logic        ex_unsigned,
  input  logic [4:0]  ex_rd,
  output logic [31:0] d_addr,
  output logic        d_we,
  output logic [3:0]  d_be,
  output logic [31:0] d_wdata,
  input  logic [31:0] d_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_excp
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_faults
`endif
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_MISA = 2'b01;
  localparam logic [1:0] EXC_OOR  = 2'b10;

  state_t      state_q, state_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [1:0]  wb_excp_q, wb_excp_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [1:0]  ld_width_q, ld_width_d;
  logic        ld_uns_q, ld_uns_d;
  logic [4:0]  ld_rd_q, ld_rd_d;

  logic        acc;
  logic        is_mem, is_store, is_load;
  logic        misal, oor, fault;
  logic [3:0]  lane_mask;
  logic [31:0] ld_shift;
  logic [31:0] ld_fmt;

  // Request classification and fault detection
  always_comb begin
    is_mem   = ex_we | ex_re;
    is_store = ex_we;
    is_load  = ex_re & ~ex_we;
    misal    = 1'b0;
    case (ex_width)
      2'b01:   misal = ex_addr[0];
      2'b10:   misal = |ex_addr[1:0];
      2'b11:   misal = 1'b1;
      default: misal = 1'b0;
    endcase
    misal = misal & is_mem;
    oor   = is_mem & (ex_addr >= 32'(DMEM_BYTES));
    fault = misal | oor;
  end

  assign ex_ready = (state_q == IDLE) & (~wb_valid_q | wb_ready);
  assign acc      = ex_valid & ex_ready;

  // RAM request port, driven straight from the execute-stage inputs
  always_comb begin
    lane_mask = '0;
    case (ex_width)
      2'b00:   lane_mask = 4'b0001 << ex_addr[1:0];
      2'b01:   lane_mask = 4'b0011 << ex_addr[1:0];
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = '0;
    endcase
    d_addr  = {ex_addr[31:2], 2'b00};
    d_we    = acc & is_store & ~fault;
    d_be    = d_we ? lane_mask : '0;
    d_wdata = ex_wdata << {ex_addr[1:0], 3'b000};
  end

  // Load data alignment and sign/zero extension
  always_comb begin
    ld_shift = d_rdata >> {ld_off_q, 3'b000};
    case (ld_width_q)
      2'b00:   ld_fmt = {{24{~ld_uns_q & ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_fmt = {{16{~ld_uns_q & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_fmt = ld_shift;
    endcase
  end

  // Next-state and writeback-register update
  always_comb begin
    state_d    = state_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_excp_d  = wb_excp_q;
    ld_off_d   = ld_off_q;
    ld_width_d = ld_width_q;
    ld_uns_d   = ld_uns_q;
    ld_rd_d    = ld_rd_q;
    case (state_q)
      IDLE: begin
        if (wb_valid_q & wb_ready) wb_valid_d = 1'b0;
        if (acc) begin
          if (fault) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_addr;
            wb_rd_d    = '0;
            wb_excp_d  = misal ? EXC_MISA : EXC_OOR;
          end else if (is_store) begin
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
            wb_rd_d    = '0;
            wb_excp_d  = EXC_NONE;
          end else if (is_load) begin
            // Result register drains (or is empty) as the load goes out;
            // it is refilled from RD_WAIT.
            state_d    = RD_WAIT;
            wb_valid_d = 1'b0;
            ld_off_d   = ex_addr[1:0];
            ld_width_d = ex_width;
            ld_uns_d   = ex_unsigned;
            ld_rd_d    = ex_rd;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_addr;
            wb_rd_d    = ex_rd;
            wb_excp_d  = EXC_NONE;
          end
        end
      end
      RD_WAIT: begin
        state_d    = IDLE;
        wb_valid_d = 1'b1;
        wb_data_d  = ld_fmt;
        wb_rd_d    = ld_rd_q;
        wb_excp_d  = EXC_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_excp_q  <= '0;
      ld_off_q   <= '0;
      ld_width_q <= '0;
      ld_uns_q   <= 1'b0;
      ld_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_excp_q  <= wb_excp_d;
      ld_off_q   <= ld_off_d;
      ld_width_q <= ld_width_d;
      ld_uns_q   <= ld_uns_d;
      ld_rd_q    <= ld_rd_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_excp  = wb_excp_q;

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] perf_loads_q, perf_stores_q, perf_faults_q;

  // Saturating counters of accepted legal loads, legal stores and faults
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_faults_q <= '0;
    end else if (acc) begin
      if (fault) begin
        if (perf_faults_q != '1) perf_faults_q <= perf_faults_q + 32'd1;
      end else if (is_store) begin
        if (perf_stores_q != '1) perf_stores_q <= perf_stores_q + 32'd1;
      end else if (is_load) begin
        if (perf_loads_q != '1) perf_loads_q <= perf_loads_q + 32'd1;
      end
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_faults = perf_faults_q;
`endif

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Self-checking bench for rv32i_mem_stage: table of request vectors with a
// writeback scoreboard, plus backpressure and reset-during-load sequences.
module tb_rv32i_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_addr, ex_wdata;
  logic        ex_we, ex_re;
  logic [1:0]  ex_width;
  logic        ex_unsigned;
  logic [4:0]  ex_rd;
  logic [31:0] d_addr;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_excp;

  rv32i_mem_stage #(.DMEM_BYTES(2048)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_we(ex_we), .ex_re(ex_re),
    .ex_width(ex_width), .ex_unsigned(ex_unsigned), .ex_rd(ex_rd),
    .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_excp(wb_excp)
  );

  always #5 clk = ~clk;

  // Synchronous byte-enabled data RAM, read data one cycle after address
  logic [31:0] mem [0:511];
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
  always @(posedge clk) begin
    d_rdata <= mem[d_addr[10:2]];
    if (d_we)
      for (int b = 0; b < 4; b++)
        if (d_be[b]) mem[d_addr[10:2]][8*b +: 8] <= d_wdata[8*b +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        we, re;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic [1:0]  exp_excp;
    logic        exp_dwe;
    logic [3:0]  exp_be;
    logic [31:0] exp_dwdata;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  excp;
    int          exp_cyc;
    bit          chk_lat;
  } sb_t;

  sb_t  exp_q[$];
  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic re, input logic [1:0] width,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic [31:0] exp_data,
                              input logic [4:0] exp_rd, input logic [1:0] exp_excp,
                              input logic exp_dwe, input logic [3:0] exp_be,
                              input logic [31:0] exp_dwdata, input int lat);
    vec_t v;
    v.we = we; v.re = re; v.width = width; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.rd = rd; v.exp_data = exp_data; v.exp_rd = exp_rd;
    v.exp_excp = exp_excp; v.exp_dwe = exp_dwe; v.exp_be = exp_be;
    v.exp_dwdata = exp_dwdata; v.lat = lat;
    return v;
  endfunction

  // Writeback monitor: every transfer is popped and compared
  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got data %h rd %0d with no pending request", wb_data, wb_rd);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_excp", 32'(wb_excp), 32'(e.excp));
        if (e.chk_lat) chk("wb_latency_cycle", cyc, e.exp_cyc);
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, check the RAM port
  task automatic issue(input vec_t v, input bit chk_lat, output int waits);
    sb_t e;
    ex_we = v.we; ex_re = v.re; ex_width = v.width; ex_unsigned = v.uns;
    ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd; ex_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!ex_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!ex_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ex_ready stayed 0 for addr %h", v.addr);
    end else begin
      chk("d_addr", d_addr, {v.addr[31:2], 2'b00});
      chk("d_we", 32'(d_we), 32'(v.exp_dwe));
      chk("d_be", 32'(d_be), 32'(v.exp_be));
      chk("d_wdata", d_wdata, v.exp_dwdata);
      e.data = v.exp_data; e.rd = v.exp_rd; e.excp = v.exp_excp;
      e.exp_cyc = cyc + v.lat; e.chk_lat = chk_lat;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  initial begin
    int w;
    vec_t v;
    logic [31:0] snap_data;
    logic [4:0]  snap_rd;
    logic [1:0]  snap_excp;

    //          we re wd u  addr          wdata         rd  exp_data      erd ex dwe be       dwdata        lat
    vecs.push_back(mk(1,0,0,0,32'h51,      32'h1191,     7, 32'h0,        0, 0, 1, 4'b0010, 32'h00119100, 1));
    vecs.push_back(mk(1,0,2,0,32'hC,       32'h12345678, 3, 32'h0,        0, 0, 1, 4'b1111, 32'h12345678, 1));
    vecs.push_back(mk(0,1,0,0,32'hD,       32'h0,        5, 32'h56,       5, 0, 0, 4'b0000, 32'h0,        2));
    vecs.push_back(mk(0,1,1,0,32'hE,       32'h0,        6, 32'h1234,     6, 0, 0, 4'b0000, 32'h0,        2));
    vecs.push_back(mk(0,1,2,0,32'hC,       32'h0,        7, 32'h12345678, 7, 0, 0, 4'b0000, 32'h0,        2));
    vecs.push_back(mk(1,0,2,0,32'h50,      32'h0,        1, 32'h0,        0, 0, 1, 4'b1111, 32'h0,        1));
    vecs.push_back(mk(1,0,0,0,32'h50,      32'h80,       1, 32'h0,        0, 0, 1, 4'b0001, 32'h80,       1));
    vecs.push_back(mk(0,1,0,0,32'h50,      32'h0,        8, 32'hFFFFFF80, 8, 0, 0, 4'b0000, 32'h0,        2));
    vecs.push_back(mk(0,1,0,1,32'h50,      32'h0,        9, 32'h80,       9, 0, 0, 4'b0000, 32'h0,        2));
    vecs.push_back(mk(0,1,1,1,32'h50,      32'h0,       10, 32'h80,      10, 0, 0, 4'b0000, 32'h0,        2));
    vecs.push_back(mk(0,0,3,0,32'hDEADBEEF,32'h0,       11, 32'hDEADBEEF,11, 0, 0, 4'b0000, 32'h0,        1));
    vecs.push_back(mk(0,1,1,0,32'h51,      32'h0,       12, 32'h51,       0, 1, 0, 4'b0000, 32'h0,        1));
    vecs.push_back(mk(1,0,2,0,32'h800,     32'hCAFEF00D,13, 32'h800,      0, 2, 0, 4'b0000, 32'hCAFEF00D, 1));
    vecs.push_back(mk(0,1,2,0,32'h802,     32'h0,       14, 32'h802,      0, 1, 0, 4'b0000, 32'h0,        1));
    vecs.push_back(mk(1,0,0,0,32'h7FF,     32'hA5,      15, 32'h0,        0, 0, 1, 4'b1000, 32'hA5000000, 1));
    vecs.push_back(mk(0,1,0,1,32'h7FF,     32'h0,       16, 32'hA5,      16, 0, 0, 4'b0000, 32'h0,        2));
    vecs.push_back(mk(0,1,0,0,32'h7FF,     32'h0,       17, 32'hFFFFFFA5,17, 0, 0, 4'b0000, 32'h0,        2));
    vecs.push_back(mk(1,1,1,0,32'h12,      32'hBEEF,    18, 32'h0,        0, 0, 1, 4'b1100, 32'hBEEF0000, 1));
    vecs.push_back(mk(0,1,1,0,32'h12,      32'h0,       19, 32'hFFFFBEEF,19, 0, 0, 4'b0000, 32'h0,        2));
    vecs.push_back(mk(0,1,3,0,32'h20,      32'h0,       20, 32'h20,       0, 1, 0, 4'b0000, 32'h0,        1));
    vecs.push_back(mk(0,1,0,0,32'h800,     32'h0,       21, 32'h800,      0, 2, 0, 4'b0000, 32'h0,        1));

    reset = 1'b1; ex_valid = 1'b0; wb_ready = 1'b1;
    ex_addr = '0; ex_wdata = '0; ex_we = 1'b0; ex_re = 1'b0;
    ex_width = '0; ex_unsigned = 1'b0; ex_rd = '0;
    repeat (3) @(negedge clk);
    chk("reset_wb_valid", 32'(wb_valid), 32'h0);
    chk("reset_wb_data", wb_data, 32'h0);
    chk("reset_wb_rd", 32'(wb_rd), 32'h0);
    chk("reset_wb_excp", 32'(wb_excp), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ex_ready", 32'(ex_ready), 32'h1);
    @(posedge clk); #1;

    // Table of single requests with full-throughput writeback
    foreach (vecs[i]) issue(vecs[i], 1'b1, w);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure on a load result, then drain with same-cycle accept
    wb_ready = 1'b0;
    issue(mk(0,1,2,0,32'hC,32'h0,22,32'h12345678,22,0,0,4'b0000,32'h0,2), 1'b0, w);
    w = 0;
    @(negedge clk);
    while (!wb_valid && w < 10) begin
      w++;
      @(negedge clk);
    end
    chk("bp_wb_valid_seen", 32'(wb_valid), 32'h1);
    snap_data = wb_data; snap_rd = wb_rd; snap_excp = wb_excp;
    chk("bp_load_data", snap_data, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(wb_valid), 32'h1);
      chk("bp_hold_data", wb_data, snap_data);
      chk("bp_hold_rd", 32'(wb_rd), 32'(snap_rd));
      chk("bp_hold_excp", 32'(wb_excp), 32'(snap_excp));
      chk("bp_ex_ready_low", 32'(ex_ready), 32'h0);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    issue(mk(0,0,0,0,32'h1234,32'h0,23,32'h1234,23,0,0,4'b0000,32'h0,1), 1'b1, w);
    chk("bp_same_cycle_accept_waits", 32'(w), 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // Reset pulse while the load is in RD_WAIT drops the load
    issue(mk(0,1,0,0,32'h50,32'h0,24,32'hFFFFFF80,24,0,0,4'b0000,32'h0,2), 1'b0, w);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_wb_valid", 32'(wb_valid), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ex_ready", 32'(ex_ready), 32'h1);
    chk("rst_mid_no_stale", 32'(wb_valid), 32'h0);
    @(negedge clk);
    chk("rst_mid_no_stale2", 32'(wb_valid), 32'h0);
    @(posedge clk); #1;
    issue(mk(0,1,2,0,32'hC,32'h0,25,32'h12345678,25,0,0,4'b0000,32'h0,2), 1'b1, w);

    // Drain outstanding expectations
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_stage.md
Name: rv32i_mem_stage

Overview:
- Pipeline memory-access stage between execute (ALU result, rs2 data) and writeback.
- Converts an execute-stage request into a word-aligned access on the synchronous dual-port data RAM port: address, write enable, byte enables, lane-shifted write data.
- Captures the RAM read data one cycle later and formats it as a 32-bit register value with sign or zero extension.
- Detects misaligned and out-of-range accesses; valid/ready handshake on both sides.

Parameters:
- DMEM_BYTES, 2048: data RAM size in bytes. Legal byte addresses are 0 .. DMEM_BYTES-1; must be a power of two.

Ports:
- clk  in  1  stage clock, same as the RAM clk
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  request present
- ex_ready  out  1  stage accepts request this cycle
- ex_addr  in  32  ALU result: byte address, or pass-through result for non-memory ops
- ex_wdata  in  32  rs2 store data, right-aligned
- ex_we  in  1  store
- ex_re  in  1  load
- ex_width  in  2  00 byte, 01 half, 10 word, 11 illegal
- ex_unsigned  in  1  zero-extend load (LBU/LHU)
- ex_rd  in  5  destination register
- d_addr  out  32  RAM address {ex_addr[31:2],2'b00}
- d_we  out  1  RAM write enable
- d_be  out  4  RAM byte-lane enables
- d_wdata  out  32  lane-shifted store data
- d_rdata  in  32  RAM read data, valid one cycle after address is sampled
- wb_valid  out  1  writeback result valid
- wb_ready  in  1  writeback consumes result
- wb_data  out  32  result or faulting address
- wb_rd  out  5  destination register; 0 for stores and faults
- wb_excp  out  2  00 none, 01 misaligned, 10 out of range

Behaviour:
- Accept: acc = ex_valid & ex_ready; ex_ready = (state==IDLE) & (!wb_valid | wb_ready).
- FSM states: IDLE, RD_WAIT.
  - IDLE -> RD_WAIT on acc of a legal load.
  - RD_WAIT -> IDLE unconditionally after 1 cycle.
- Fault rules:
  - misaligned: width 01 with addr[0]=1; width 10 with addr[1:0]!=0; width 11 always.
  - out of range: addr >= DMEM_BYTES.
  - Misaligned takes priority when both apply.
  - Fault checks apply only when ex_we|ex_re.
- RAM port (combinational from ex_* inputs):
  - d_addr is driven at all times.
  - d_we = acc & ex_we & no fault.
  - d_be: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111. Forced to 0 when d_we=0.
  - d_wdata = ex_wdata << (8*addr[1:0]).
- ex_we & ex_re both set: treated as a store.
- Latency:
  - Store, non-memory op, or any fault: wb_valid rises the cycle after acc.
  - Legal load: acc in cycle N, RD_WAIT in N+1 (d_rdata sampled), wb_valid rises in N+2.
- Load format: t = d_rdata >> (8*addr[1:0]), using the address registered at acc.
  - byte: t[7:0] extended from bit 7, or zero-extended if unsigned.
  - half: t[15:0] extended from bit 15, or zero-extended if unsigned.
  - word: t.
- wb_data per request type:
  - non-memory op: ex_addr.
  - store: 0.
  - fault: the faulting ex_addr.
  - wb_rd = ex_rd only for loads and non-memory ops, otherwise 0.
- Backpressure: wb_valid, wb_data, wb_rd and wb_excp hold stable until wb_valid & wb_ready.
  - In RD_WAIT the wb register is guaranteed empty, so no extra buffer is needed.
- Simultaneous drain and accept: allowed in IDLE; the new result overwrites in the same edge as the drain.
- Reset (any time, including mid-load in RD_WAIT):
  - state IDLE; wb_valid 0, wb_data 0, wb_rd 0, wb_excp 0.
  - Any in-flight load is dropped.
  - ex_ready is 1 in the first cycle after deassertion.

Optional Feature:
- Macro: MEM_STAGE_PERF_EN.
- Defined:
  - Adds outputs perf_loads, perf_stores, perf_faults (32 bits each).
  - Each is a saturating count of accepted legal loads, legal stores and faulted requests.
  - Counters reset to 0 and hold at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Store byte: addr 0x51, data 0x1191, width 00 -> d_addr 0x50, d_be 0010, d_wdata 0x00119100, d_we 1; next cycle wb_valid=1, wb_rd=0, wb_excp 00.
- Store word 0x12345678 @0xC, then loads:
  - signed byte @0xD -> wb_data 0x00000056, two cycles after acc.
  - signed half @0xE -> 0x00001234.
  - word @0xC -> 0x12345678.
- Store byte 0x80 @0x50, then loads @0x50:
  - signed byte -> 0xFFFFFF80.
  - unsigned byte -> 0x00000080.
  - unsigned half -> 0x00000080.
- Faults:
  - half load @0x51 -> d_we 0, wb_excp 01, wb_data 0x51, wb_rd 0, latency 1.
  - word store @0x800 (DMEM_BYTES 2048) -> d_we 0, wb_excp 10.
- Backpressure: wb_ready=0 for 3 cycles after a load result -> wb_* stable, ex_ready 0; when wb_ready=1, same-cycle accept of the next request.
- Reset pulse during RD_WAIT -> wb_valid stays 0, no stale result; following load @0xC returns 0x12345678.
